aud_sample_packer: RTL and testbench
====================================

# aud_sample_packer

Producer-side counterpart of the PWM audio output stage. Accepts a stream of unsigned DATA_WIDTH-bit audio samples over a valid/ready handshake and packs LANES = FIFO_DATA_WIDTH/DATA_WIDTH samples per word, earliest sample in the lowest byte. Packed words are buffered in an internal first-word-fall-through FIFO, which the PWM stage drains through `fifo_rd_data`, `aud_en` and `rd_en`.

## Interface
- DATA_WIDTH, 8, sample width in bits
- FIFO_DATA_WIDTH, 32, packed word width; must be an integer multiple of DATA_WIDTH
- FIFO_DEPTH, 8, word entries; must be a power of 2 and at least 2
- clk  in  1  the single clock; all logic is rising-edge
- rst  in  1  asynchronous reset, active-high
- s_data  in  DATA_WIDTH  input sample
- s_valid  in  1  `s_data` is valid
- s_ready  out  1  sample is accepted on a cycle where `s_valid && s_ready`
- flush  in  1  one-cycle request to close a partial word
- rd_en  in  1  pops the head word; ignored when the FIFO is empty
- fifo_rd_data  out  FIFO_DATA_WIDTH  head word; all zeros when the FIFO is empty
- aud_en  out  1  FIFO not empty
- level  out  $clog2(FIFO_DEPTH)+1  number of words held
- underrun  out  1  one-cycle pulse on `rd_en` while the FIFO is empty

## Operation
- Lane counter `lane` runs 0..LANES-1. An accepted sample is written to assembly-register bits `[lane*DATA_WIDTH +: DATA_WIDTH]`.
- **Normal word completion:** when the accepted sample fills lane LANES-1, the completed word (assembly register plus that sample) is pushed to the FIFO on the same edge, and `lane` returns to 0.
- `s_ready = !flush_pend && (lane != LANES-1 || !full)`. It never depends combinationally on `rd_en`.
- **Flush:** a `flush` pulse sets `flush_pend` when `lane != 0` (after accounting for any sample accepted in the same cycle). It is a no-op when `lane == 0`.
- While `flush_pend` is set and the FIFO is not full, the partial word is pushed with all unfilled lanes padded to PAD = 1 << (DATA_WIDTH-1) (0x80, PWM midscale). Then `lane` returns to 0 and `flush_pend` clears.
- **Flush and sample in the same cycle:**
  - The sample is packed first.
  - If that sample completes the word, the word is pushed normally and the flush is a no-op.
  - Otherwise the flush applies to the word that now includes the sample.
- **Read side:** `rd_en` with the FIFO not empty advances the head. `rd_en` with the FIFO empty produces `underrun` = 1 for that cycle only and changes no state.
- **Simultaneous push and pop:** `level` is unchanged and both operations take effect.
- **Full:** a push never occurs while full, because `s_ready` and the flush path both gate on `!full`.
- **Reset values:** `s_ready` 1, `fifo_rd_data` 0, `aud_en` 0, `level` 0, `underrun` 0, `lane` 0, `flush_pend` 0, pointers 0. FIFO storage is not reset.
- **Reset asserted mid-word or mid-flush:** partial data and the pending flush are discarded.

## Timing
- The push edge is the edge on which the last sample is accepted, or the edge on which the flush push happens. `aud_en`, `level` and `fifo_rd_data` reflect the push one cycle after that edge; they are registered-state outputs.
- Pop: the next head word appears on `fifo_rd_data` in the cycle after the `rd_en` edge.
- Throughput: one sample per cycle sustained while the FIFO is not full. Filling lanes 0..LANES-2 never stalls.
- `underrun` is combinational from `rd_en && empty` and is sampled by the consumer at the next edge.

## Configuration
- `AUD_PACK_UNDERRUN_CNT_EN` defined:
  - Adds output port `underrun_cnt` [15:0], which counts `underrun` pulses.
  - The counter saturates at 0xFFFF and resets to 0 on `rst`.
- Not defined: the port and the counter are absent, and `underrun` is the only indication.

## Structure
- Package `aud_pack_pkg` holds:
  - the LANES computation;
  - the PAD sample function of DATA_WIDTH;
  - the lane index typedef;
  - a compile-time check that FIFO_DATA_WIDTH is a multiple of DATA_WIDTH.
- Sub-module `aud_word_fifo` is a synchronous FWFT FIFO with:
  - wr_en/wr_data, rd_en/rd_data;
  - empty/full/level;
  - pointers of $clog2(FIFO_DEPTH)+1 bits with an MSB wrap bit;
  - zeros on rd_data when empty.
- The packer logic (lane counter, assembly register, flush_pend, underrun counter) lives in the top.

## Test plan
- Reset, then samples 0x11, 0x22, 0x33, 0x44 on four consecutive cycles → one cycle after the 4th accept, `aud_en` = 1, `level` = 1, `fifo_rd_data` = 0x44332211.
- Samples 0xAA, 0xBB then a `flush` pulse → pushed word 0x8080BBAA, `lane` = 0. A `flush` with `lane` = 0 pushes nothing.
- Sample 0xCC accepted with `flush` in the same cycle at `lane` = 2 → word 0x80CCxxxx. At `lane` = 3 → a normal full word with no extra push.
- Stream 8×4 samples with `rd_en` = 0 → `level` = 8 and `s_ready` drops at `lane` = 3. One `rd_en` → `s_ready` high the next cycle, the pending sample is accepted, and the word order is preserved.
- `rd_en` on an empty FIFO → `underrun` = 1 for one cycle, `level` stays 0. With the macro defined, `underrun_cnt` increments and saturates at 0xFFFF.
- Assert `rst` mid-word (`lane` = 2) and with `flush_pend` set → all outputs return to their reset values immediately, and the next four samples form a fresh word.

Source files
------------

// File: rtl/aud_pack_pkg.sv
// Shared definitions for the audio sample packer: lane math, pad sample,
// lane index type and configuration sanity check.
package aud_pack_pkg;

   // Wide enough for up to 256 lanes per packed word.
   localparam int LANE_IDX_W = 8;

   typedef logic [LANE_IDX_W-1:0] lane_idx_t;

   function automatic int lanes_of(input int fw, input int dw);
      return fw / dw;
   endfunction

   // PWM midscale for an unsigned sample of width dw.
   function automatic logic [63:0] pad_sample(input int dw);
      return 64'd1 << (dw - 1);
   endfunction

   function automatic bit cfg_ok(input int fw, input int dw);
      return (dw > 0) && (fw >= dw) && ((fw % dw) == 0)
         && ((fw / dw) <= (1 << LANE_IDX_W));
   endfunction

endpackage

// File: rtl/aud_word_fifo.sv
// Synchronous first-word-fall-through FIFO for packed audio words.
// Ports: clk, rst (async, high), wr_en/wr_data, rd_en/rd_data (zero when
// empty), empty, full, level (words held).
module aud_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   // Same slot, opposite lap: writer is a full lap ahead.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
               && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/aud_sample_packer.sv
// Packs DATA_WIDTH-bit audio samples into FIFO_DATA_WIDTH-bit words (earliest
// sample in the lowest lane) and buffers them in a FWFT FIFO for the PWM stage.
// Ports: clk, rst (async, high); s_data/s_valid/s_ready sample input; flush
// closes a partial word with midscale padding; rd_en/fifo_rd_data/aud_en/level
// read side; underrun pulses on a read of an empty FIFO.
// Option AUD_PACK_UNDERRUN_CNT_EN adds the saturating 16-bit underrun_cnt.
module aud_sample_packer
   import aud_pack_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int FIFO_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic                         flush,
   input  logic                         rd_en,
   output logic [FIFO_DATA_WIDTH-1:0]   fifo_rd_data,
   output logic                         aud_en,
   output logic [$clog2(FIFO_DEPTH):0]  level,
   output logic                         underrun
`ifdef AUD_PACK_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                  underrun_cnt
`endif
);

   localparam int LANES = lanes_of(FIFO_DATA_WIDTH, DATA_WIDTH);
   localparam lane_idx_t LAST = lane_idx_t'(LANES - 1);
   localparam logic [DATA_WIDTH-1:0] PAD =
      DATA_WIDTH'(pad_sample(DATA_WIDTH));

   if (!cfg_ok(FIFO_DATA_WIDTH, DATA_WIDTH)) begin : g_cfg_err
      $error("FIFO_DATA_WIDTH must be a multiple of DATA_WIDTH");
   end

   lane_idx_t                  lane_q, lane_d, lane_adv;
   logic [FIFO_DATA_WIDTH-1:0] asm_q, asm_d;
   logic                       flush_pend_q, flush_pend_d;

   logic                       full, empty;
   logic                       lane_last, accept;
   logic                       push_norm, push_flush, wr_en;
   logic [FIFO_DATA_WIDTH-1:0] word_in, pad_word, wr_data;

   assign lane_last  = (lane_q == LAST);
   // Only the last lane needs FIFO space; earlier lanes never stall.
   assign s_ready    = !flush_pend_q && (!lane_last || !full);
   assign accept     = s_valid && s_ready;
   assign push_norm  = accept && lane_last;
   assign push_flush = flush_pend_q && !full;
   assign wr_en      = push_norm || push_flush;

   // Assembly register with the sample accepted this cycle merged in.
   always_comb begin
      word_in = asm_q;
      if (accept) begin
         word_in[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
   end

   // Lanes at or above the fill point hold stale data; replace with midscale.
   always_comb begin
      pad_word = asm_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_idx_t'(i) >= lane_q) begin
            pad_word[i*DATA_WIDTH +: DATA_WIDTH] = PAD;
         end
      end
   end

   always_comb begin
      lane_adv = lane_q;
      if (accept) begin
         lane_adv = lane_last ? '0 : lane_q + lane_idx_t'(1);
      end
      lane_d       = push_flush ? '0 : lane_adv;
      asm_d        = word_in;
      flush_pend_d = flush_pend_q;
      if (push_flush) begin
         flush_pend_d = 1'b0;
      end else if (flush && (lane_adv != '0)) begin
         flush_pend_d = 1'b1;
      end
      wr_data = push_flush ? pad_word : word_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q       <= '0;
         asm_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         asm_q        <= asm_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   aud_word_fifo #(
      .WIDTH (FIFO_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (fifo_rd_data),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

   assign aud_en   = !empty;
   assign underrun = rd_en && empty;

`ifdef AUD_PACK_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_q, urun_cnt_d;

   assign urun_cnt_d = (underrun && (urun_cnt_q != 16'hFFFF))
                     ? urun_cnt_q + 16'd1 : urun_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         urun_cnt_q <= '0;
      end else begin
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_aud_sample_packer.sv
// Randomized self-checking bench for aud_sample_packer against a
// queue-based reference model of the packing and FIFO behaviour.
module tb_aud_sample_packer;

   localparam int DW    = 8;
   localparam int FW    = 32;
   localparam int DEPTH = 8;
   localparam int LANES = FW / DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          flush = 1'b0;
   logic          rd_en = 1'b0;
   logic [FW-1:0] fifo_rd_data;
   logic          aud_en;
   logic [3:0]    level;
   logic          underrun;
`ifdef AUD_PACK_UNDERRUN_CNT_EN
   logic [15:0]   underrun_cnt;
`endif

   always #5 clk = ~clk;

   aud_sample_packer #(
      .DATA_WIDTH      (DW),
      .FIFO_DATA_WIDTH (FW),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .flush        (flush),
      .rd_en        (rd_en),
      .fifo_rd_data (fifo_rd_data),
      .aud_en       (aud_en),
      .level        (level),
      .underrun     (underrun)
`ifdef AUD_PACK_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   logic [FW-1:0] mq[$];
   logic [DW-1:0] cur[$];
   bit            pend;
   int            ucnt;
   int            n_chk;
   int            n_pass;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [FW-1:0] pack_word(input logic [DW-1:0] s[$]);
      logic [FW-1:0] w;
      logic [DW-1:0] b;
      w = '0;
      for (int i = 0; i < LANES; i++) begin
         b = (i < s.size()) ? s[i] : 8'h80;
         w = w | (FW'(b) << (DW * i));
      end
      return w;
   endfunction

   task automatic step(input bit v, input logic [DW-1:0] d,
                       input bit f, input bit r);
      bit            exp_rdy, exp_ur, do_pop, push;
      logic [FW-1:0] pw;
      @(negedge clk);
      s_valid = v;
      s_data  = d;
      flush   = f;
      rd_en   = r;
      #1;
      exp_rdy = !pend && (cur.size() != LANES - 1 || mq.size() != DEPTH);
      exp_ur  = r && (mq.size() == 0);
      check("s_ready", 32'(s_ready), 32'(exp_rdy));
      check("aud_en", 32'(aud_en), 32'(mq.size() != 0));
      check("level", 32'(level), 32'(mq.size()));
      check("rd_data", fifo_rd_data, (mq.size() != 0) ? mq[0] : 32'h0);
      check("underrun", 32'(underrun), 32'(exp_ur));
`ifdef AUD_PACK_UNDERRUN_CNT_EN
      check("urun_cnt", 32'(underrun_cnt), 32'(ucnt));
`endif
      @(posedge clk);
      if (exp_ur && ucnt < 65535) ucnt++;
      do_pop = r && (mq.size() != 0);
      push   = 1'b0;
      pw     = '0;
      if (pend) begin
         if (mq.size() < DEPTH) begin
            pw   = pack_word(cur);
            push = 1'b1;
            cur.delete();
            pend = 1'b0;
         end
      end else begin
         if (v && exp_rdy) begin
            cur.push_back(d);
            if (cur.size() == LANES) begin
               pw   = pack_word(cur);
               push = 1'b1;
               cur.delete();
            end
         end
         if (f && cur.size() != 0) pend = 1'b1;
      end
      if (do_pop) void'(mq.pop_front());
      if (push) mq.push_back(pw);
   endtask

   task automatic do_reset();
      @(negedge clk);
      s_valid = 1'b0;
      flush   = 1'b0;
      rd_en   = 1'b0;
      rst     = 1'b1;
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_aud_en", 32'(aud_en), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rd_data", fifo_rd_data, 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      mq.delete();
      cur.delete();
      pend = 1'b0;
      ucnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      pend   = 1'b0;
      ucnt   = 0;
      do_reset();

      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      #2;
      check("word_full", fifo_rd_data, 32'h44332211);
      check("level_one", 32'(level), 32'd1);
      step(0, 8'h00, 0, 1);

      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      #2;
      check("word_flush", fifo_rd_data, 32'h8080BBAA);
      step(0, 8'h00, 0, 1);

      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      #2;
      check("flush_idle", 32'(level), 32'd0);

      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      step(1, 8'hCC, 1, 0);
      step(0, 8'h00, 0, 0);
      #2;
      check("word_flush_smp", fifo_rd_data, 32'h80CC0201);
      step(0, 8'h00, 0, 1);

      step(1, 8'h05, 0, 0);
      step(1, 8'h06, 0, 0);
      step(1, 8'h07, 0, 0);
      step(1, 8'h08, 1, 0);
      step(0, 8'h00, 0, 0);
      #2;
      check("word_last_flush", fifo_rd_data, 32'h08070605);
      check("no_extra_push", 32'(level), 32'd1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);

      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      do_reset();
      step(1, 8'h09, 0, 0);
      step(0, 8'h00, 1, 0);
      do_reset();
      step(1, 8'hA1, 0, 0);
      step(1, 8'hA2, 0, 0);
      step(1, 8'hA3, 0, 0);
      step(1, 8'hA4, 0, 0);
      #2;
      check("word_after_rst", fifo_rd_data, 32'hA4A3A2A1);

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 99) < 85, 8'($urandom),
              $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 5);
      end
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 99) < 25, 8'($urandom),
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70);
      end
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 50, 8'($urandom),
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30);
      end
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step($urandom_range(0, 99) < 60, 8'($urandom),
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
